// File: rtl/limber_gnrl_ramdp_r.sv
// Simple dual-port buffer RAM: one write port, one read port, per-lane write mask,
// optional output register and a self-clearing init engine that runs after reset.
module limber_gnrl_ramdp_r #(
  parameter int unsigned   DP       = 16,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   AW       = 4,
  parameter int unsigned   MW       = 4,
  parameter int unsigned   OUT_REG  = 0,
  parameter int unsigned   RDW_MODE = 0,
  parameter logic [DW-1:0] CLR_VAL  = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_busy,
  input  logic          wcs,
  input  logic          we,
  input  logic [MW-1:0] wmask,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic          rcs,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  localparam int unsigned LW        = DW / MW;
  localparam logic [AW:0] DP_EXT    = (AW+1)'(DP);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DP - 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] mem [DP];

  logic          clr_we;
  logic          waddr_ok;
  logic          raddr_ok;
  logic          wr_qual;
  logic          rd_acc;
  logic [DW-1:0] wbits;
  logic [DW-1:0] rd_word;

  // Expand the lane mask into a bit mask so writes and bypass merge share it
  for (genvar g = 0; g < MW; g++) begin : g_lane
    assign wbits[g*LW +: LW] = {LW{wmask[g]}};
  end

  assign waddr_ok = {1'b0, waddr} < DP_EXT;
  assign raddr_ok = {1'b0, raddr} < DP_EXT;
  assign clr_we   = (state == ST_CLEAR) && !rst;
  assign wr_qual  = wcs && we && !init_busy && !rst && waddr_ok;
  assign rd_acc   = rcs && !init_busy && !rst;

  // Init engine: sweeps every word once after reset, then hands the RAM to users
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else if (state == ST_CLEAR) begin
      if (clr_cnt == LAST_ADDR) begin
        state     <= ST_IDLE;
        clr_cnt   <= '0;
        init_busy <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + AW'(1);
      end
    end
  end

  // Storage has no reset; only the clear sweep and qualified user writes touch it
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= CLR_VAL;
    end else if (wr_qual) begin
      mem[waddr] <= (mem[waddr] & ~wbits) | (din & wbits);
    end
  end

  // Out-of-range reads return the clear value; write-through merges same-edge lanes
  always_comb begin
    rd_word = raddr_ok ? mem[raddr] : CLR_VAL;
    if (RDW_MODE == 1 && wr_qual && (waddr == raddr)) begin
      rd_word = (rd_word & ~wbits) | (din & wbits);
    end
  end

  if (OUT_REG == 0) begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) begin
        dout     <= '0;
        dout_vld <= 1'b0;
      end else begin
        dout_vld <= rd_acc;
        if (rd_acc) begin
          dout <= rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic          s1_vld;
    logic [DW-1:0] s1_data;

    // Reset drops any read still in the first stage
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_vld   <= 1'b0;
        s1_data  <= '0;
        dout     <= '0;
        dout_vld <= 1'b0;
      end else begin
        s1_vld   <= rd_acc;
        dout_vld <= s1_vld;
        if (rd_acc) begin
          s1_data <= rd_word;
        end
        if (s1_vld) begin
          dout <= s1_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_limber_gnrl_ramdp_r.sv
// Bench for limber_gnrl_ramdp_r: two instances (12-word read-first latency 1,
// 16-word write-through latency 2) share one stimulus stream against a scoreboard.
module tb_limber_gnrl_ramdp_r;

  localparam logic [31:0] CLR = 32'hDEAD_BEEF;
  localparam int unsigned DPA = 12;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wcs, we, rcs;
  logic [3:0]  wmask, waddr, raddr;
  logic [31:0] din;
  logic        busy_a, busy_b, vld_a, vld_b;
  logic [31:0] dout_a, dout_b;

  logic [31:0] ma [16];
  logic [31:0] mb [16];
  exp_t        qa [$];
  exp_t        qb [$];
  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  limber_gnrl_ramdp_r #(.DP(12), .DW(32), .AW(4), .MW(4), .OUT_REG(0), .RDW_MODE(0), .CLR_VAL(CLR)) u_a (
    .clk(clk), .rst(rst), .init_busy(busy_a), .wcs(wcs), .we(we), .wmask(wmask), .waddr(waddr),
    .din(din), .rcs(rcs), .raddr(raddr), .dout(dout_a), .dout_vld(vld_a));

  limber_gnrl_ramdp_r #(.DP(16), .DW(32), .AW(4), .MW(4), .OUT_REG(1), .RDW_MODE(1), .CLR_VAL(CLR)) u_b (
    .clk(clk), .rst(rst), .init_busy(busy_b), .wcs(wcs), .we(we), .wmask(wmask), .waddr(waddr),
    .din(din), .rcs(rcs), .raddr(raddr), .dout(dout_b), .dout_vld(vld_b));

  // Scoreboard pop/compare for instance A
  always @(negedge clk) begin
    exp_t e;
    if (vld_a) begin
      n_total++;
      if (qa.size() == 0) begin
        $display("FAIL rd_a unexpected dout_vld: dout=%h, no read outstanding", dout_a);
      end else begin
        e = qa.pop_front();
        if (dout_a !== e.data || cyc != e.due)
          $display("FAIL rd_a got %h at cycle %0d, expected %h at cycle %0d", dout_a, cyc, e.data, e.due);
        else n_pass++;
      end
    end
    if (qa.size() > 0 && qa[0].due < cyc) begin
      n_total++;
      $display("FAIL rd_a missing dout_vld: expected %h at cycle %0d, now %0d", qa[0].data, qa[0].due, cyc);
      qa.delete(0);
    end
  end

  // Scoreboard pop/compare for instance B
  always @(negedge clk) begin
    exp_t e;
    if (vld_b) begin
      n_total++;
      if (qb.size() == 0) begin
        $display("FAIL rd_b unexpected dout_vld: dout=%h, no read outstanding", dout_b);
      end else begin
        e = qb.pop_front();
        if (dout_b !== e.data || cyc != e.due)
          $display("FAIL rd_b got %h at cycle %0d, expected %h at cycle %0d", dout_b, cyc, e.data, e.due);
        else n_pass++;
      end
    end
    if (qb.size() > 0 && qb[0].due < cyc) begin
      n_total++;
      $display("FAIL rd_b missing dout_vld: expected %h at cycle %0d, now %0d", qb[0].data, qb[0].due, cyc);
      qb.delete(0);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      ma[i] = CLR;
      mb[i] = CLR;
    end
  endtask

  task automatic idle(input int n);
    wcs = 1'b0; we = 1'b0; rcs = 1'b0; wmask = '0;
    repeat (n) @(negedge clk);
  endtask

  // One cycle of traffic; called at a negedge, returns at the next negedge
  task automatic do_op(input logic w, input logic [3:0] wm, input logic [3:0] wa, input logic [31:0] d,
                       input logic r, input logic [3:0] ra);
    logic [31:0] wb;
    exp_t e;
    wb = {{8{wm[3]}}, {8{wm[2]}}, {8{wm[1]}}, {8{wm[0]}}};
    wcs = w; we = w; wmask = wm; waddr = wa; din = d; rcs = r; raddr = ra;
    if (r) begin
      e.data = (ra < 4'(DPA)) ? ma[ra] : CLR;
      e.due  = cyc + 1;
      qa.push_back(e);
      e.data = mb[ra];
      if (w && wa == ra) e.data = (e.data & ~wb) | (d & wb);
      e.due  = cyc + 2;
      qb.push_back(e);
    end
    if (w) begin
      if (wa < 4'(DPA)) ma[wa] = (ma[wa] & ~wb) | (d & wb);
      mb[wa] = (mb[wa] & ~wb) | (d & wb);
    end
    @(negedge clk);
  endtask

  // Counts busy cycles after rst falls; optionally pokes traffic into the first busy cycle
  task automatic count_busy(input logic poke, output int ca, output int cb, output logic dout_bad);
    ca = 0; cb = 0; dout_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (poke && i == 0) begin
        wcs = 1'b1; we = 1'b1; wmask = 4'hF; waddr = 4'd2; din = 32'h5555_5555; rcs = 1'b1; raddr = 4'd2;
      end else begin
        wcs = 1'b0; we = 1'b0; rcs = 1'b0;
      end
      if (busy_a === 1'b1) ca++;
      if (busy_b === 1'b1) cb++;
      if ((busy_a === 1'b1 && dout_a !== 32'h0) || (busy_b === 1'b1 && dout_b !== 32'h0)) dout_bad = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = '0; waddr = '0; raddr = '0;
    idle(3);
    n_total++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) $display("FAIL reset_busy got a=%b b=%b expected 1/1", busy_a, busy_b);
    else n_pass++;
    n_total++;
    if (dout_a !== 32'h0 || dout_b !== 32'h0) $display("FAIL reset_dout got a=%h b=%h expected 0/0", dout_a, dout_b);
    else n_pass++;
    n_total++;
    if (vld_a !== 1'b0 || vld_b !== 1'b0) $display("FAIL reset_vld got a=%b b=%b expected 0/0", vld_a, vld_b);
    else n_pass++;
  endtask

  task automatic test_init();
    int ca, cb;
    logic bad;
    rst = 1'b0;
    model_clear();
    count_busy(1'b0, ca, cb, bad);
    n_total++;
    if (ca != 12) $display("FAIL init_busy_a got %0d cycles expected 12", ca); else n_pass++;
    n_total++;
    if (cb != 16) $display("FAIL init_busy_b got %0d cycles expected 16", cb); else n_pass++;
    n_total++;
    if (bad) $display("FAIL init_dout nonzero while busy, expected 0"); else n_pass++;
    for (int i = 0; i < 16; i++) do_op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
    idle(3);
  endtask

  task automatic test_masked_write();
    do_op(1'b1, 4'hF, 4'd3, 32'h1122_3344, 1'b0, 4'd0);
    do_op(1'b1, 4'b0101, 4'd3, 32'hAABB_CCDD, 1'b0, 4'd0);
    do_op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    do_op(1'b1, 4'h0, 4'd3, 32'hFFFF_FFFF, 1'b0, 4'd0);
    idle(4);
    n_total++;
    if (dout_a !== 32'h11BB_33DD || vld_a !== 1'b0) $display("FAIL hold_a got %h vld=%b expected 11bb33dd vld=0", dout_a, vld_a);
    else n_pass++;
    n_total++;
    if (dout_b !== 32'h11BB_33DD || vld_b !== 1'b0) $display("FAIL hold_b got %h vld=%b expected 11bb33dd vld=0", dout_b, vld_b);
    else n_pass++;
    do_op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    idle(3);
  endtask

  task automatic test_gating();
    wcs = 1'b1; we = 1'b0; wmask = 4'hF; waddr = 4'd7; din = 32'h7777_7777; rcs = 1'b0;
    @(negedge clk);
    wcs = 1'b0; we = 1'b1;
    @(negedge clk);
    do_op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7);
    idle(3);
  endtask

  task automatic test_rdw();
    do_op(1'b1, 4'hF, 4'd5, 32'h0, 1'b0, 4'd0);
    do_op(1'b1, 4'b0011, 4'd5, 32'hFFFF_FFFF, 1'b1, 4'd5);
    do_op(1'b1, 4'hF, 4'd6, 32'h6666_6666, 1'b1, 4'd5);
    do_op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd6);
    idle(3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) do_op(1'b1, 4'hF, 4'(i), 32'(i), 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) do_op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'(i));
    idle(3);
  endtask

  task automatic test_out_of_range();
    do_op(1'b1, 4'hF, 4'd13, 32'h0000_1234, 1'b0, 4'd0);
    do_op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd13);
    for (int i = 0; i < 12; i++) do_op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'(i));
    idle(3);
  endtask

  task automatic test_reset_mid_clear();
    int ca, cb;
    logic bad;
    exp_t e;
    rcs = 1'b1; raddr = 4'd4; wcs = 1'b0; we = 1'b0;
    e.data = ma[4]; e.due = cyc + 1;
    qa.push_back(e);
    @(negedge clk);
    rst = 1'b1; rcs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(1'b1, ca, cb, bad);
    n_total++;
    if (ca != 12) $display("FAIL restart_busy_a got %0d cycles expected 12", ca); else n_pass++;
    n_total++;
    if (cb != 16) $display("FAIL restart_busy_b got %0d cycles expected 16", cb); else n_pass++;
    n_total++;
    if (bad) $display("FAIL restart_dout nonzero while busy, expected 0"); else n_pass++;
    do_op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);
    do_op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5);
    idle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom(),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    idle(4);
    n_total++;
    if (qa.size() != 0 || qb.size() != 0) $display("FAIL drain got %0d/%0d pending reads expected 0/0", qa.size(), qb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_masked_write();
    test_gating();
    test_rdw();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/limber_gnrl_ramdp_r.md
Name: limber_gnrl_ramdp_r

Overview:
- Simple dual-port RAM: one write port and one read port.
- Synchronous read, per-lane write mask, optional output pipeline register and selectable read-during-write policy.
- Self-clearing init engine: after reset, every location is written to CLR_VAL before the RAM accepts traffic.
- Used as the general-purpose buffer RAM under register files, FIFOs and DMA staging in the Limber MCU.

Parameters:
- DP, 16: depth in words. 2 <= DP <= 2^AW.
- DW, 32: data width in bits. Must be divisible by MW.
- AW, 4: address width.
- MW, 4: write-mask width. Lane i covers bits [(i+1)*DW/MW-1 : i*DW/MW].
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- RDW_MODE, 0: read-during-write at the same address. 0 = old data (read-first); 1 = new data (write-through, merged per lane).
- CLR_VAL, 0: DW-bit value written to every word by the init engine.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the init engine is clearing memory.
- wcs  in  1  write-port chip select.
- we  in  1  write enable. A write occurs when wcs & we & ~init_busy.
- wmask  in  MW  per-lane write enable.
- waddr  in  AW  write address.
- din  in  DW  write data.
- rcs  in  1  read request. Accepted when rcs & ~init_busy.
- raddr  in  AW  read address.
- dout  out  DW  read data.
- dout_vld  out  1  one-cycle pulse: dout carries the data for an accepted read.

Behaviour:
- Reset values:
  - init_busy=1 while rst=1.
  - dout=0, dout_vld=0, and all pipeline valids cleared.
  - Clear counter = 0.
- Init FSM has two states, CLEAR and IDLE.
  - rst forces CLEAR with counter=0.
  - In CLEAR, each posedge with rst=0 writes CLR_VAL to mem[counter] (all lanes), then counter increments.
  - When the edge writes address DP-1, the FSM moves to IDLE.
  - init_busy is high for exactly DP cycles after rst deasserts, and low from the cycle after the write to DP-1.
  - rst asserted mid-clear restarts the counter at 0. A partial clear is not resumed.
- While init_busy=1:
  - User writes are dropped and user reads are ignored.
  - dout holds 0 and dout_vld stays 0.
- Write:
  - On a posedge with a qualified write, mem[waddr] lane i <= din lane i for every i with wmask[i]=1.
  - Other lanes are unchanged.
  - wmask=0 is a legal no-op.
- Read:
  - Request accepted at edge T.
  - OUT_REG=0: dout and dout_vld=1 are valid during cycle T+1.
  - OUT_REG=1: dout and dout_vld=1 are valid during cycle T+2.
  - Back-to-back reads are fully pipelined, one per cycle, with no bubbles.
- dout holds its last value when no read completes. dout_vld is 0 on those cycles.
- Read-during-write, same address at the same edge:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns, per lane, din where wmask=1 and the old data elsewhere.
  - Different addresses do not interact.
- Out-of-range address (>= DP, only possible when DP < 2^AW):
  - The write is dropped.
  - The read is accepted, dout_vld pulses, and dout returns CLR_VAL.
- No X propagation: the memory is fully initialised by the clear, so dout is never X after init_busy falls.
- Simultaneous rst and traffic: rst wins. An in-flight read in the OUT_REG pipeline is discarded, so dout_vld does not fire.
- Storage is a plain reg array with no reset. Only the init engine and user writes modify it.

Test Plan:
1. Init: DP=16, CLR_VAL=32'hDEAD_BEEF. Deassert rst, then read addresses 0..15 after init_busy falls. Expect init_busy high for exactly 16 cycles, and every read returns 32'hDEAD_BEEF with dout_vld one cycle after the request (OUT_REG=0).
2. Masked write: write addr 3 din=32'h1122_3344 wmask=4'hF, then din=32'hAABB_CCDD wmask=4'b0101, then read addr 3. Expect 32'h11BB_33DD.
3. Read-during-write: mem[5]=32'h0, then same-edge write addr 5 din=32'hFFFF_FFFF wmask=4'b0011 with read addr 5. Expect RDW_MODE=0 → 32'h0000_0000; RDW_MODE=1 → 32'h0000_FFFF.
4. Pipeline: OUT_REG=1, reads of addr 0..7 on 8 consecutive cycles (preloaded mem[i]=i). Expect dout_vld high for 8 consecutive cycles starting 2 cycles after the first request, with dout=0..7 in order.
5. Reset mid-clear: assert rst for 1 cycle after 7 clear cycles. Expect init_busy to stay high for 16 further cycles. A write attempted at addr 2 during busy is dropped, so a read of addr 2 returns CLR_VAL.
6. Out-of-range: DP=12, AW=4. Write addr 13 with 32'h1234, then read addr 13. Expect dout=CLR_VAL, dout_vld=1, and mem[0..11] unchanged.
